// File: rtl/bsg_manycore_reset_sequencer.sv
// ---------------------------------------------------------------------------
// bsg_manycore_reset_sequencer
//
// Reset and bring-up sequencer for the manycore test harness. It releases
// per-channel (pod / IO complex) resets on a staggered schedule and
// synchronises each channel's tag-programming-done into a sticky bit. It
// holds the host/DPI endpoint in reset until every enabled channel has
// reported done, waits a short settle period, and then releases the host.
// It records the cycle of that release and flags a sticky timeout if
// bring-up hangs.
//
// Ports:
//   clk_i            clock
//   reset_i          synchronous active-high reset
//   channel_en_i     per-channel enable mask (level, expected static)
//   tag_done_i       per-channel tag-programming-done (asynchronous level)
//   channel_reset_o  per-channel reset to pods (1 = held in reset)
//   host_reset_o     reset to host/DPI endpoint
//   all_done_o       bring-up complete
//   timeout_o        bring-up timed out (sticky until reset_i)
//   done_cycle_o     cycle count at host release
//   state_o          0 RESET, 1 WAIT_TAG, 2 SETTLE, 3 RUN, 4 TIMEOUT
// ---------------------------------------------------------------------------
module bsg_manycore_reset_sequencer #(
   parameter int num_channels_p   = 4,
   parameter int reset_depth_p    = 3,
   parameter int stagger_p        = 1,
   parameter int settle_cycles_p  = 2,
   parameter int timeout_cycles_p = 10000,
   parameter int ctr_width_p      = 64
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [num_channels_p-1:0] channel_en_i,
   input  logic [num_channels_p-1:0] tag_done_i,
   output logic [num_channels_p-1:0] channel_reset_o,
   output logic                      host_reset_o,
   output logic                      all_done_o,
   output logic                      timeout_o,
   output logic [ctr_width_p-1:0]    done_cycle_o,
   output logic [2:0]                state_o
);

   typedef enum logic [2:0] {
      S_RESET    = 3'd0,
      S_WAIT_TAG = 3'd1,
      S_SETTLE   = 3'd2,
      S_RUN      = 3'd3,
      S_TIMEOUT  = 3'd4
   } state_e;

   // Elapsed-edge counter saturates once every schedule point (last channel
   // release, timeout) has been reached, so a narrow done_cycle counter that
   // wraps can never re-trigger a release or a timeout.
   localparam int rel_max_lp  = reset_depth_p + (num_channels_p - 1) * stagger_p;
   localparam int sat_lp      = (rel_max_lp > timeout_cycles_p) ? rel_max_lp : timeout_cycles_p;
   localparam int elap_w_lp   = $clog2(sat_lp + 1);
   localparam int settle_w_lp = (settle_cycles_p > 1) ? $clog2(settle_cycles_p) : 1;

   localparam logic [elap_w_lp-1:0]   elap_sat_lp  = elap_w_lp'(sat_lp);
   localparam bit                     to_en_lp     = (timeout_cycles_p != 0);
   localparam logic [elap_w_lp-1:0]   to_th_lp     = elap_w_lp'(to_en_lp ? timeout_cycles_p - 1 : 0);
   localparam logic [settle_w_lp-1:0] settle_last_lp = settle_w_lp'(settle_cycles_p - 1);

   logic [ctr_width_p-1:0]    cyc_q, cyc_d;
   logic [elap_w_lp-1:0]      elap_q, elap_d;
   logic [num_channels_p-1:0] reached;
   logic [num_channels_p-1:0] chan_rst_q, chan_rst_d;
   logic [num_channels_p-1:0] tag_sync;
   logic [num_channels_p-1:0] done_q, done_d;
   logic                      all_ok;
   logic                      timed_out;

   state_e                    state_q;
   logic [settle_w_lp-1:0]    settle_q;
   logic                      host_rst_q;
   logic                      all_done_q;
   logic                      timeout_q;
   logic [ctr_width_p-1:0]    done_cyc_q;

   // Free-running cycle counter; holds n after edge Tn.
   assign cyc_d  = cyc_q + ctr_width_p'(1);
   assign elap_d = (elap_q == elap_sat_lp) ? elap_q : elap_q + elap_w_lp'(1);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cyc_q  <= '0;
         elap_q <= '0;
      end else begin
         cyc_q  <= cyc_d;
         elap_q <= elap_d;
      end
   end

   // Channel i is due for release at edge T(depth + i*stagger); elap_q is
   // n-1 while edge Tn is being evaluated, hence the -1 in the threshold.
   for (genvar i = 0; i < num_channels_p; i++) begin : g_rel
      localparam logic [elap_w_lp-1:0] th_lp = elap_w_lp'(reset_depth_p + i * stagger_p - 1);
      assign reached[i] = (elap_q >= th_lp);
   end

   // Not gated by state: a channel enabled late is released on the next edge.
   assign chan_rst_d = ~(channel_en_i & reached);

   always_ff @(posedge clk_i) begin
      if (reset_i) chan_rst_q <= '1;
      else         chan_rst_q <= chan_rst_d;
   end

   // The sticky done bit is the last flop of the synchroniser, so only
   // reset_depth_p-1 plain flops sit in front of it.
   if (reset_depth_p == 1) begin : g_nosync
      assign tag_sync = tag_done_i;
   end else begin : g_sync
      logic [num_channels_p-1:0] sync_q [reset_depth_p-1];
      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            for (int k = 0; k < reset_depth_p - 1; k++) sync_q[k] <= '0;
         end else begin
            sync_q[0] <= tag_done_i;
            for (int k = 1; k < reset_depth_p - 1; k++) sync_q[k] <= sync_q[k-1];
         end
      end
      assign tag_sync = sync_q[reset_depth_p-2];
   end

   assign done_d = done_q | tag_sync;

   always_ff @(posedge clk_i) begin
      if (reset_i) done_q <= '0;
      else         done_q <= done_d;
   end

   assign all_ok    = &(done_q | ~channel_en_i);
   assign timed_out = to_en_lp && (elap_q >= to_th_lp);

   // Bring-up FSM with registered outputs. SETTLE takes priority over the
   // timeout when both are due on the same edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_RESET;
         settle_q   <= '0;
         host_rst_q <= 1'b1;
         all_done_q <= 1'b0;
         timeout_q  <= 1'b0;
         done_cyc_q <= '0;
      end else begin
         case (state_q)
            S_RESET: begin
               state_q <= S_WAIT_TAG;
            end
            S_WAIT_TAG: begin
               if (all_ok) begin
                  state_q  <= S_SETTLE;
                  settle_q <= '0;
               end else if (timed_out) begin
                  state_q   <= S_TIMEOUT;
                  timeout_q <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (settle_q == settle_last_lp) begin
                  state_q    <= S_RUN;
                  host_rst_q <= 1'b0;
                  all_done_q <= 1'b1;
                  done_cyc_q <= cyc_d;
               end else begin
                  settle_q <= settle_q + settle_w_lp'(1);
               end
            end
            S_RUN, S_TIMEOUT: begin
               state_q <= state_q;
            end
            default: begin
               state_q <= S_RESET;
            end
         endcase
      end
   end

   assign channel_reset_o = chan_rst_q;
   assign host_reset_o    = host_rst_q;
   assign all_done_o      = all_done_q;
   assign timeout_o       = timeout_q;
   assign done_cycle_o    = done_cyc_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_bsg_manycore_reset_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for bsg_manycore_reset_sequencer: directed scenarios with a
// schedule-level reference model checked every cycle, plus literal
// expectations at key edges.
// ---------------------------------------------------------------------------
module tb_bsg_manycore_reset_sequencer;
   localparam int N   = 4;
   localparam int D   = 3;
   localparam int S   = 2;
   localparam int SET = 2;
   localparam int TO  = 20;
   localparam int CW  = 32;

   logic          clk;
   logic          rst;
   logic [N-1:0]  en;
   logic [N-1:0]  tag;
   logic [N-1:0]  chrst;
   logic          host_rst;
   logic          all_done;
   logic          tmo;
   logic [CW-1:0] done_cyc;
   logic [2:0]    state;

   bsg_manycore_reset_sequencer #(
      .num_channels_p(N), .reset_depth_p(D), .stagger_p(S),
      .settle_cycles_p(SET), .timeout_cycles_p(TO), .ctr_width_p(CW)
   ) dut (
      .clk_i(clk), .reset_i(rst), .channel_en_i(en), .tag_done_i(tag),
      .channel_reset_o(chrst), .host_reset_o(host_rst), .all_done_o(all_done),
      .timeout_o(tmo), .done_cycle_o(done_cyc), .state_o(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The model works on edge numbers: n edges since reset, first edge at
   // which each tag was seen, edge at which SETTLE or TIMEOUT began.
   logic   mv = 1'b0;
   int     m_n;
   int     first_tag [N];
   int     settle_edge;
   int     to_edge;
   int     e_state;
   logic [N-1:0] e_chrst;

   always @(posedge clk) begin
      mv = 1'b1;
      if (rst) begin
         m_n = 0;
         for (int i = 0; i < N; i++) first_tag[i] = -1;
         settle_edge = 0;
         to_edge = 0;
      end else begin
         bit ok;
         m_n++;
         ok = 1'b1;
         for (int i = 0; i < N; i++)
            if (en[i] && !(first_tag[i] >= 0 && first_tag[i] + D - 1 <= m_n - 1)) ok = 1'b0;
         if (m_n >= 2 && settle_edge == 0 && to_edge == 0) begin
            if (ok) settle_edge = m_n;
            else if (m_n >= TO) to_edge = m_n;
         end
         for (int i = 0; i < N; i++)
            if (tag[i] && first_tag[i] < 0) first_tag[i] = m_n;
      end
      if (m_n == 0)             e_state = 0;
      else if (settle_edge != 0) e_state = (m_n >= settle_edge + SET) ? 3 : 2;
      else if (to_edge != 0)     e_state = 4;
      else                       e_state = 1;
      for (int i = 0; i < N; i++)
         e_chrst[i] = !(m_n > 0 && en[i] && m_n >= D + i * S);
   end

   always @(negedge clk) begin
      if (mv) begin
         chk("m_state", 64'(state), 64'(e_state));
         chk("m_chrst", 64'(chrst), 64'(e_chrst));
         chk("m_host_rst", 64'(host_rst), 64'(e_state != 3));
         chk("m_all_done", 64'(all_done), 64'(e_state == 3));
         chk("m_timeout", 64'(tmo), 64'(e_state == 4));
         chk("m_done_cycle", 64'(done_cyc), (e_state == 3) ? 64'(settle_edge + SET) : 64'd0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic reset_seq();
      rst = 1'b1;
      tag = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Returns at the falling edge after Tk.
   task automatic step_to(input int k);
      while (m_n < k) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      en  = '0;
      tag = '0;

      // Staggered release, then tags seen at T10 -> RUN at T15.
      reset_seq();
      chk("reset_state", 64'(state), 64'd0);
      chk("reset_chrst", 64'(chrst), 64'hF);
      chk("reset_host", 64'(host_rst), 64'd1);
      en = 4'b1111;
      step_to(2);  chk("A_chrst_T2", 64'(chrst), 64'hF);
      step_to(3);  chk("A_chrst_T3", 64'(chrst), 64'hE);
      step_to(5);  chk("A_chrst_T5", 64'(chrst), 64'hC);
      step_to(7);  chk("A_chrst_T7", 64'(chrst), 64'h8);
      step_to(9);  chk("A_chrst_T9", 64'(chrst), 64'h0);
      chk("A_host_T9", 64'(host_rst), 64'd1);
      tag = 4'b1111;
      step_to(12); chk("A_state_T12", 64'(state), 64'd1);
      step_to(13); chk("A_state_T13", 64'(state), 64'd2);
      step_to(14); chk("A_host_T14", 64'(host_rst), 64'd1);
      step_to(15);
      chk("A_host_T15", 64'(host_rst), 64'd0);
      chk("A_done_T15", 64'(all_done), 64'd1);
      chk("A_cycle_T15", 64'(done_cyc), 64'd15);
      step_to(20); chk("A_cycle_T20", 64'(done_cyc), 64'd15);

      // Reset pulse during SETTLE, then the same sequence repeats.
      reset_seq();
      en = 4'b1111;
      step_to(9);  tag = 4'b1111;
      step_to(14); chk("E_state_T14", 64'(state), 64'd2);
      rst = 1'b1;
      @(negedge clk);
      chk("E_rst_state", 64'(state), 64'd0);
      chk("E_rst_chrst", 64'(chrst), 64'hF);
      chk("E_rst_cycle", 64'(done_cyc), 64'd0);
      tag = '0;
      rst = 1'b0;
      step_to(3);  chk("E_chrst_T3", 64'(chrst), 64'hE);
      step_to(9);  tag = 4'b1111;
      step_to(13); chk("E_state_T13", 64'(state), 64'd2);
      step_to(15); chk("E_cycle_T15", 64'(done_cyc), 64'd15);

      // Only ch0/ch2 enabled, tags sampled at T4 -> RUN at T9.
      reset_seq();
      en = 4'b0101;
      step_to(3);  tag = 4'b0101;
      step_to(8);  chk("B_state_T8", 64'(state), 64'd2);
      step_to(9);
      chk("B_state_T9", 64'(state), 64'd3);
      chk("B_chrst_T9", 64'(chrst), 64'hA);
      chk("B_cycle_T9", 64'(done_cyc), 64'd9);

      // Last tag makes all_ok exactly at T20: SETTLE wins over timeout.
      reset_seq();
      en = 4'b1111;
      step_to(1);  tag = 4'b0111;
      step_to(16); tag = 4'b1111;
      step_to(19); chk("D_state_T19", 64'(state), 64'd1);
      step_to(20);
      chk("D_state_T20", 64'(state), 64'd2);
      chk("D_tmo_T20", 64'(tmo), 64'd0);
      step_to(22); chk("D_cycle_T22", 64'(done_cyc), 64'd22);

      // One edge too late: timeout at T20; a later tag has no effect.
      reset_seq();
      en = 4'b1111;
      step_to(1);  tag = 4'b0111;
      step_to(17); tag = 4'b1111;
      step_to(20);
      chk("C_state_T20", 64'(state), 64'd4);
      chk("C_tmo_T20", 64'(tmo), 64'd1);
      chk("C_host_T20", 64'(host_rst), 64'd1);
      step_to(30);
      chk("C_state_T30", 64'(state), 64'd4);
      chk("C_chrst_T30", 64'(chrst), 64'h0);

      // All channels disabled: SETTLE at T2, RUN at T4; late enable of ch1.
      reset_seq();
      en = 4'b0000;
      step_to(2);  chk("F_state_T2", 64'(state), 64'd2);
      step_to(4);
      chk("F_state_T4", 64'(state), 64'd3);
      chk("F_cycle_T4", 64'(done_cyc), 64'd4);
      step_to(5);  chk("F_chrst_T5", 64'(chrst), 64'hF);
      en = 4'b0010;
      step_to(6);  chk("F_chrst_T6", 64'(chrst), 64'hD);
      step_to(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
